// File: rtl/fir_pkg.sv
// Shared constants for the single-channel FIR core and the state type of its sample loader.
package fir_pkg;

    localparam int DATA_WIDTH = 16;
    localparam int ADDR_WIDTH = 16;
    localparam int DATA_NUM   = 65536;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        SETTLE = 3'd2,
        RUN    = 3'd3,
        DONE   = 3'd4
    } loader_state_t;

endpackage

// File: rtl/fir_sample_loader.sv
// Loads one frame of stream samples into the FIR data memory, holds the core in reset while
// loading, releases it, and waits (with a watchdog) for the core's done interrupt.
module fir_sample_loader
    import fir_pkg::*;
#(
    parameter int DATA_WIDTH  = fir_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH  = fir_pkg::ADDR_WIDTH,
    parameter int DATA_NUM    = fir_pkg::DATA_NUM,
    parameter int SETTLE_CYC  = 2,
    parameter int RUN_TIMEOUT = 65600
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic                  abort_i,
    input  logic                  s_valid_i,
    input  logic [DATA_WIDTH-1:0] s_data_i,
    output logic                  s_ready_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_wr_o,
    output logic [DATA_WIDTH-1:0] mem_din_o,
    output logic                  mem_we_o,
    output logic                  fir_rst_o,
    input  logic                  fir_done_i,
    output logic                  busy_o,
    output logic                  frame_done_o,
    output logic                  err_o
);

    // One extra bit so a full 2**ADDR_WIDTH frame never wraps the count.
    localparam int CNT_W = ADDR_WIDTH + 1;
    localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam int WD_W  = $clog2(RUN_TIMEOUT + 1);

    loader_state_t    state_reg, state_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic [SET_W-1:0] settle_reg, settle_next;
    logic [WD_W-1:0]  wd_reg, wd_next;
    logic             err_reg, err_next;

    logic                  mem_we_reg;
    logic [ADDR_WIDTH-1:0] mem_addr_reg;
    logic [DATA_WIDTH-1:0] mem_din_reg;
    logic                  fir_rst_reg;

    logic handshake;

    assign s_ready_o     = (state_reg == LOAD);
    assign handshake     = s_valid_i && s_ready_o;
    assign busy_o        = (state_reg != IDLE);
    assign frame_done_o  = (state_reg == DONE);
    assign err_o         = err_reg;
    assign mem_we_o      = mem_we_reg;
    assign mem_addr_wr_o = mem_addr_reg;
    assign mem_din_o     = mem_din_reg;
    assign fir_rst_o     = fir_rst_reg;

    always_comb begin
        state_next  = state_reg;
        count_next  = count_reg;
        settle_next = settle_reg;
        wd_next     = wd_reg;
        err_next    = err_reg;
        if (abort_i) begin
            state_next = IDLE;
            count_next = '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start_i) begin
                        state_next = LOAD;
                        count_next = '0;
                        err_next   = 1'b0;
                    end
                end
                LOAD: begin
                    if (handshake) begin
                        count_next = count_reg + 1'b1;
                        if (count_reg == CNT_W'(DATA_NUM - 1)) begin
                            state_next  = SETTLE;
                            settle_next = '0;
                        end
                    end
                end
                SETTLE: begin
                    settle_next = settle_reg + 1'b1;
                    if (settle_reg == SET_W'(SETTLE_CYC - 1)) begin
                        state_next = RUN;
                        wd_next    = '0;
                    end
                end
                RUN: begin
                    wd_next = wd_reg + 1'b1;
                    // A done arriving on the last watchdog cycle still counts as success.
                    if (fir_done_i) begin
                        state_next = DONE;
                    end else if (wd_reg == WD_W'(RUN_TIMEOUT - 1)) begin
                        state_next = IDLE;
                        err_next   = 1'b1;
                    end
                end
                DONE: state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= IDLE;
            count_reg  <= '0;
            settle_reg <= '0;
            wd_reg     <= '0;
            err_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            count_reg  <= count_next;
            settle_reg <= settle_next;
            wd_reg     <= wd_next;
            err_reg    <= err_next;
        end
    end

    // An aborted cycle discards its sample instead of writing it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_we_reg   <= 1'b0;
            mem_addr_reg <= '0;
            mem_din_reg  <= '0;
            fir_rst_reg  <= 1'b1;
        end else begin
            mem_we_reg  <= handshake && !abort_i;
            fir_rst_reg <= (state_next != RUN);
            if (handshake && !abort_i) begin
                mem_addr_reg <= count_reg[ADDR_WIDTH-1:0];
                mem_din_reg  <= s_data_i;
            end
        end
    end

endmodule
